// File: rtl/rv32i_pkg.sv
// Shared RV32I front-end definitions: datapath width, canonical NOP and the
// fetch-to-decode entry layout.
package rv32i_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            pc_error;
  } if_id_entry_t;

endpackage

// File: rtl/en_ff.sv
// Enable flop cell: captures d on a rising edge when en is high, else holds.
module en_ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (en) q <= d;
  end

endmodule

// File: rtl/if_id_skid_buffer.sv
// Two-entry valid/ready buffer between fetch and decode; flush drops all
// wrong-path entries, errored entries are presented to decode as a NOP.
import rv32i_pkg::*;

module if_id_skid_buffer #(
  parameter int              XLEN      = rv32i_pkg::XLEN,
  parameter logic [XLEN-1:0] NOP_INSTR = rv32i_pkg::NOP_INSTR
) (
  input  logic            decode_clk,
  input  logic            decode_rst,
  input  logic            in_valid,
  input  logic [XLEN-1:0] in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            in_pc_error,
  output logic            in_ready,
  input  logic            flush,
  output logic            out_valid,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic            out_pc_error,
  input  logic            out_ready,
  output logic [1:0]      fill_level,
  output logic            err_seen
);

  logic [1:0]   count_q, count_d;
  logic         wptr_q, wptr_d;
  logic         rptr_q, rptr_d;
  logic         err_seen_q, err_seen_d;
  logic         push, pop;
  if_id_entry_t wr_entry;
  if_id_entry_t head;
  if_id_entry_t entry_q [2];

  assign wr_entry = '{pc: in_pc, instr: in_instr, pc_error: in_pc_error};

  for (genvar i = 0; i < 2; i++) begin : g_entry
    en_ff #(.W($bits(if_id_entry_t))) u_entry (
      .clk (decode_clk),
      .en  (push && (wptr_q == 1'(i))),
      .d   (wr_entry),
      .q   (entry_q[i])
    );
  end

  assign head = entry_q[rptr_q];

  // Handshake depends only on registered state and reset, never on out_ready.
  assign in_ready   = (count_q != 2'd2) && decode_rst;
  assign out_valid  = (count_q != 2'd0) && decode_rst;
  assign fill_level = decode_rst ? count_q : 2'd0;
  assign err_seen   = err_seen_q;

  assign push = in_valid && in_ready && !flush;
  assign pop  = out_valid && out_ready && !flush;

  always_comb begin
    out_instr    = NOP_INSTR;
    out_pc       = '0;
    out_pc_error = 1'b0;
    if (out_valid) begin
      out_pc       = head.pc;
      out_pc_error = head.pc_error;
      if (!head.pc_error) out_instr = head.instr;
    end
  end

  always_comb begin
    count_d    = count_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    err_seen_d = err_seen_q || (pop && head.pc_error);
    if (flush) begin
      count_d = 2'd0;
      wptr_d  = 1'b0;
      rptr_d  = 1'b0;
    end else begin
      if (push) wptr_d = ~wptr_q;
      if (pop)  rptr_d = ~rptr_q;
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge decode_clk) begin
    if (!decode_rst) begin
      count_q    <= 2'd0;
      wptr_q     <= 1'b0;
      rptr_q     <= 1'b0;
      err_seen_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      err_seen_q <= err_seen_d;
    end
  end

endmodule

// File: tb/tb_if_id_skid_buffer.sv
// Directed bench for the IF/ID skid buffer: reset, transfer, backpressure,
// streaming, flush, errored entries and mid-operation reset.
module tb_if_id_skid_buffer;

  logic        decode_clk = 1'b0;
  logic        decode_rst;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        in_pc_error;
  logic        in_ready;
  logic        flush;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_pc_error;
  logic        out_ready;
  logic [1:0]  fill_level;
  logic        err_seen;

  int checks = 0;
  int errors = 0;

  if_id_skid_buffer dut (
    .decode_clk   (decode_clk),
    .decode_rst   (decode_rst),
    .in_valid     (in_valid),
    .in_instr     (in_instr),
    .in_pc        (in_pc),
    .in_pc_error  (in_pc_error),
    .in_ready     (in_ready),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_instr    (out_instr),
    .out_pc       (out_pc),
    .out_pc_error (out_pc_error),
    .out_ready    (out_ready),
    .fill_level   (fill_level),
    .err_seen     (err_seen)
  );

  always #5 decode_clk = ~decode_clk;

  task automatic step();
    @(posedge decode_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic offer(input logic [31:0] pc, input logic [31:0] instr, input logic err);
    in_valid    = 1'b1;
    in_pc       = pc;
    in_instr    = instr;
    in_pc_error = err;
  endtask

  initial begin
    decode_rst  = 1'b0;
    in_valid    = 1'b0;
    in_instr    = '0;
    in_pc       = '0;
    in_pc_error = 1'b0;
    flush       = 1'b0;
    out_ready   = 1'b0;

    // Reset held for three cycles
    step(); step(); step();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_instr", out_instr, 32'h13);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_fill", 32'(fill_level), 32'd0);
    decode_rst = 1'b1;
    #1;
    chk("rel_in_ready", 32'(in_ready), 32'd1);
    chk("rel_fill", 32'(fill_level), 32'd0);
    chk("rel_err_seen", 32'(err_seen), 32'd0);

    // Single transfer
    out_ready = 1'b1;
    offer(32'h0, 32'h0050_0093, 1'b0);
    step();
    in_valid = 1'b0;
    chk("single_valid", 32'(out_valid), 32'd1);
    chk("single_pc", out_pc, 32'h0);
    chk("single_instr", out_instr, 32'h0050_0093);
    chk("single_fill", 32'(fill_level), 32'd1);
    step();
    chk("single_drained", 32'(out_valid), 32'd0);
    chk("single_nop", out_instr, 32'h13);

    // Backpressure
    out_ready = 1'b0;
    offer(32'h0, 32'hA000_0000, 1'b0);
    step();
    offer(32'h4, 32'hA000_0004, 1'b0);
    step();
    chk("bp_fill2", 32'(fill_level), 32'd2);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    offer(32'h8, 32'hA000_0008, 1'b0);
    step();
    in_valid = 1'b0;
    chk("bp_fill_hold", 32'(fill_level), 32'd2);
    chk("bp_head_stable", out_pc, 32'h0);
    chk("bp_head_instr", out_instr, 32'hA000_0000);
    out_ready = 1'b1;
    step();
    chk("bp_second_pc", out_pc, 32'h4);
    chk("bp_second_instr", out_instr, 32'hA000_0004);
    chk("bp_fill1", 32'(fill_level), 32'd1);
    step();
    chk("bp_empty", 32'(out_valid), 32'd0);
    offer(32'h8, 32'hA000_0008, 1'b0);
    step();
    in_valid = 1'b0;
    chk("bp_third_pc", out_pc, 32'h8);
    step();
    chk("bp_third_drained", 32'(fill_level), 32'd0);

    // Stream with simultaneous push and pop
    for (int i = 0; i < 10; i++) begin
      offer(32'(i * 4), 32'h100 + 32'(i), 1'b0);
      step();
      chk($sformatf("stream_pc_%0d", i), out_pc, 32'(i * 4));
      chk($sformatf("stream_instr_%0d", i), out_instr, 32'h100 + 32'(i));
      chk($sformatf("stream_fill_%0d", i), 32'(fill_level), 32'd1);
    end
    in_valid = 1'b0;
    step();
    chk("stream_end", 32'(fill_level), 32'd0);

    // Flush while full, with a competing offer and out_ready
    out_ready = 1'b0;
    offer(32'h10, 32'hB000_0010, 1'b0);
    step();
    offer(32'h14, 32'hB000_0014, 1'b0);
    step();
    chk("fl_full", 32'(fill_level), 32'd2);
    offer(32'h100, 32'hB000_0100, 1'b0);
    out_ready = 1'b1;
    flush     = 1'b1;
    #1;
    chk("fl_in_ready", 32'(in_ready), 32'd0);
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl_fill", 32'(fill_level), 32'd0);
    chk("fl_valid", 32'(out_valid), 32'd0);
    offer(32'h200, 32'hB000_0200, 1'b0);
    step();
    in_valid = 1'b0;
    chk("fl_next_pc", out_pc, 32'h200);
    step();

    // Flush at count 1 must also drop an acceptable incoming entry
    out_ready = 1'b0;
    offer(32'h300, 32'hC000_0300, 1'b0);
    step();
    offer(32'h304, 32'hC000_0304, 1'b0);
    out_ready = 1'b1;
    flush     = 1'b1;
    #1;
    chk("fl1_in_ready", 32'(in_ready), 32'd1);
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl1_fill", 32'(fill_level), 32'd0);
    chk("fl1_err_seen", 32'(err_seen), 32'd0);

    // Errored entry
    out_ready = 1'b0;
    offer(32'hFFFF_FFFC, 32'hDEAD_BEEF, 1'b1);
    step();
    in_valid = 1'b0;
    chk("err_flag", 32'(out_pc_error), 32'd1);
    chk("err_instr", out_instr, 32'h13);
    chk("err_pc", out_pc, 32'hFFFF_FFFC);
    chk("err_not_yet", 32'(err_seen), 32'd0);
    out_ready = 1'b1;
    step();
    chk("err_seen_set", 32'(err_seen), 32'd1);
    chk("err_popped", 32'(out_valid), 32'd0);
    chk("err_flag_clr", 32'(out_pc_error), 32'd0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("err_sticky", 32'(err_seen), 32'd1);

    // Reset mid-operation
    out_ready = 1'b0;
    offer(32'h400, 32'hD000_0400, 1'b0);
    step();
    in_valid   = 1'b0;
    decode_rst = 1'b0;
    #1;
    chk("mrst_valid", 32'(out_valid), 32'd0);
    chk("mrst_in_ready", 32'(in_ready), 32'd0);
    chk("mrst_pc", out_pc, 32'h0);
    step();
    decode_rst = 1'b1;
    #1;
    chk("mrst_fill", 32'(fill_level), 32'd0);
    chk("mrst_err_clr", 32'(err_seen), 32'd0);
    offer(32'h500, 32'hD000_0500, 1'b0);
    step();
    in_valid = 1'b0;
    chk("mrst_first_push", out_pc, 32'h500);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_id_skid_buffer.md
Name: if_id_skid_buffer

Overview:
- 2-entry valid/ready pipeline buffer between instruction fetch and decode in the RV32I core.
- Captures fetched instruction, its PC and its pc_error flag, and presents them in order to decode.
- Decouples decode stalls from fetch and drops wrong-path instructions on control-flow redirect (flush).

Parameters:
- XLEN, 32, data/address width of instruction and PC fields.
- NOP_INSTR, 32'h0000_0013, instruction (addi x0,x0,0) driven on out_instr whenever no valid, error-free entry is presented.

Ports:
- decode_clk  in  1  stage clock; all state updates on rising edge.
- decode_rst  in  1  reset, synchronous, active-low.
- in_valid  in  1  fetch presents a valid instruction.
- in_instr  in  XLEN  fetched instruction.
- in_pc  in  XLEN  PC of in_instr.
- in_pc_error  in  1  fetch PC overflow flag for in_instr.
- in_ready  out  1  buffer can accept this cycle.
- flush  in  1  redirect (jump/branch taken): discard all held and incoming entries.
- out_valid  out  1  head entry valid toward decode.
- out_instr  out  XLEN  head instruction (NOP_INSTR when out_valid=0 or out_pc_error=1).
- out_pc  out  XLEN  head PC (0 when out_valid=0).
- out_pc_error  out  1  head entry error flag (0 when out_valid=0).
- out_ready  in  1  decode accepts head this cycle.
- fill_level  out  2  entries held, 0..2.
- err_seen  out  1  sticky: an errored entry was popped since reset.

Behaviour:
- Storage: 2 entries {pc, instr, pc_error}; 1-bit write pointer, 1-bit read pointer, 2-bit count; pointers wrap 1->0.
- in_ready = (count != 2) AND decode_rst high; depends only on registered state and reset, never on out_ready or in_valid. No combinational in-to-out pass-through.
- push = in_valid & in_ready & ~flush; pop = out_valid & out_ready & ~flush.
- Latency: entry pushed in cycle N is visible on out_* in cycle N+1 if the buffer was empty.
- out_valid = (count != 0). out_* are driven from the head entry, selected by read pointer.
- push only: write at wptr, wptr++, count++. pop only: rptr++, count--. Push and pop together (count is 1 and in_ready=1): both pointers advance, count unchanged. Push with count 2 cannot occur because in_ready=0.
- Full (count 2): in_ready=0 and head is held stable until popped. Empty (count 0): out_valid=0, out_instr=NOP_INSTR, out_pc=0, out_pc_error=0.
- Flush has priority over push and pop: next cycle count=0, wptr=rptr=0; the entry on in_* in the flush cycle is dropped; the head is not counted as consumed even if out_ready=1. in_ready during the flush cycle reflects the current count, but nothing is accepted.
- Errored entry: stored with pc_error=1. While it is head, out_instr=NOP_INSTR and out_pc=stored pc. Popping it sets err_seen=1. err_seen clears only on reset; flush does not clear it.
- Reset (decode_rst=0 at a clock edge): count=0, pointers=0, err_seen=0. While reset is low: out_valid=0, in_ready=0, out_instr=NOP_INSTR, out_pc=0, out_pc_error=0, fill_level=0. Reset mid-operation discards all entries. The first push is possible in the first cycle with decode_rst=1.
- fill_level = count.

Decomposition:
- Shared package rv32i_pkg: XLEN, NOP_INSTR constant, typedef if_id_entry_t packed struct {pc, instr, pc_error}.
- Entry registers use the existing enable-flop cell en_ff, one per entry with write-enable = push & (wptr==i). The pointer/count control stays in this module; no further sub-module.

Test Plan:
- Reset then idle: hold decode_rst=0 for 3 cycles -> in_ready=0, out_valid=0, out_instr=32'h13. Release -> in_ready=1, fill_level=0.
- Single transfer: push pc=0x0, instr=0x00500093 with out_ready=1 -> next cycle out_valid=1, out_pc=0, out_instr=0x00500093. Following cycle out_valid=0.
- Backpressure: out_ready=0, push pc 0x0/0x4/0x8 on consecutive cycles -> first two accepted, fill_level=2, in_ready=0 in third cycle, 0x8 not taken. Raise out_ready -> order 0x0, 0x4, then 0x8 once re-offered.
- Simultaneous push/pop at count 1 -> fill_level stays 1 for a 10-cycle stream pc 0x0..0x24, with every PC delivered once, in order.
- Flush: fill_level=2, assert flush with in_valid=1 (pc 0x100) and out_ready=1 -> next cycle fill_level=0, out_valid=0, pc 0x100 absent. Push pc 0x200 -> it is the next out_pc.
- Error entry: push pc=0xFFFF_FFFC, instr=0xDEADBEEF, pc_error=1 -> out_pc_error=1, out_instr=32'h13. After pop, err_seen=1, and it stays 1 through a subsequent flush.
